tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels, 1..16.
REQ-002 Parameter CNT_W, default 23: width of the per-channel period and counter.
REQ-003 Parameter CH_W, default 4: width of the channel index, sized so 2**CH_W >= NUM_CH.
REQ-004 Reset and clock SHALL be: reset reset_n, asynchronous, active-low; clock clock_in.
REQ-005 clock_in  in  1  system clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cfg_valid  in  1  configuration request valid.
REQ-008 cfg_ready  out  1  block can accept a configuration request this cycle.
REQ-009 cfg_ch  in  CH_W  target channel index.
REQ-010 cfg_period  in  CNT_W  tick period in clock_in cycles.
REQ-011 cfg_enable  in  1  1 = run channel, 0 = stop channel.
REQ-012 cfg_err  out  1  one-cycle pulse: last accepted request was invalid.
REQ-013 tick  out  NUM_CH  per-channel one-cycle enable pulses.
REQ-014 active  out  NUM_CH  per-channel running flag.

Function
REQ-015 Handshake SHALL be accepted on a rising edge where cfg_valid=1 and cfg_ready=1; cfg_ch, cfg_period and cfg_enable SHALL be captured into a holding register at that edge.
REQ-016 Control FSM SHALL have two states: IDLE (cfg_ready=1) and APPLY (cfg_ready=0); IDLE->APPLY on accept, APPLY->IDLE unconditionally after one cycle.
REQ-017 Back-to-back requests SHALL therefore sustain at most one accept every 2 cycles; cfg_valid held high during APPLY SHALL NOT be accepted.
REQ-018 In APPLY, a valid request (cfg_ch < NUM_CH, cfg_period != 0 or cfg_enable=0) SHALL load period[ch]=cfg_period, cnt[ch]=0 and en[ch]=cfg_enable at the APPLY-exit edge.
REQ-019 In APPLY, a request with cfg_ch >= NUM_CH, or with cfg_enable=1 and cfg_period=0, SHALL leave every channel unchanged and SHALL assert cfg_err for exactly the cycle after the APPLY-exit edge.
REQ-020 A running channel SHALL increment cnt[i] each cycle and SHALL wrap to 0 on the edge where cnt[i]==period[i]-1.
REQ-021 tick[i] SHALL be a combinational decode of registers: en[i] && cnt[i]==period[i]-1.
REQ-022 With period P applied at edge A, tick[i] SHALL first be high in the cycle following edge A+P-1, then every P cycles; P=1 SHALL give tick high every cycle.
REQ-023 A stopped channel (en=0) SHALL hold cnt[i] at 0 and keep tick[i]=0.
REQ-024 Reconfiguring a running channel SHALL restart its phase: cnt[i]=0 at the APPLY-exit edge, and no tick from the old period SHALL occur in the cycle after that edge.
REQ-025 Channels SHALL be fully independent; a write to channel j SHALL NOT perturb cnt, period, en or tick of any other channel.
REQ-026 active[i] SHALL equal en[i].
REQ-027 Counter arithmetic SHALL be unsigned CNT_W bits; period 2**CNT_W-1 SHALL work without overflow.

Reset
REQ-028 reset_n=0 SHALL immediately force FSM=IDLE, all en=0, cnt=0, period=0, holding register=0, cfg_err=0, tick=0, active=0.
REQ-029 cfg_ready SHALL be 1 while in reset.
REQ-030 Reset asserted during APPLY SHALL discard the pending request, and no channel SHALL be modified by it after reset release.
REQ-031 After reset_n rises, the first accept SHALL be possible on the first rising edge.

Verification
REQ-032 Write ch0 period=4 enable=1 -> cfg_ready low 1 cycle; tick[0] high in cycles 4, 8, 12 after the APPLY-exit edge, single-cycle each; other ticks 0.
REQ-033 Write ch1 period=1 enable=1 -> tick[1] high every cycle from the cycle after the APPLY-exit edge; active[1]=1.
REQ-034 ch2 running at period=5, rewrite to period=3 mid-count (cnt=2) -> no tick at old phase; next tick 3 cycles after the APPLY-exit edge.
REQ-035 Write cfg_ch=NUM_CH, then ch0 enable=1 period=0 -> cfg_err pulses once per request; all channel state unchanged.
REQ-036 cfg_valid held high for 6 cycles with distinct payloads -> exactly 3 accepts (IDLE/APPLY alternating), each applied in order.
REQ-037 Assert reset_n=0 during APPLY of ch3 period=2 -> tick=0, active=0 immediately; ch3 remains stopped after release.

Source files
------------

// File: rtl/tick_scheduler.sv
// Multi-channel periodic tick generator. Each channel is configured through a
// two-state valid/ready port and emits one-cycle pulses every `period` cycles.
module tick_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 23,
  parameter int unsigned CH_W   = 4
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_enable,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active
);

  typedef enum logic [0:0] {StIdle, StApply} state_e;

  state_e state_q, state_d;

  logic [CH_W-1:0]  hold_ch_q;
  logic [CNT_W-1:0] hold_period_q;
  logic             hold_enable_q;
  logic             err_q;

  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;

  logic accept, apply_ok, apply_bad;
  logic hold_in_range, hold_valid;

  // Widen by one bit so NUM_CH = 2**CH_W still compares correctly.
  assign hold_in_range = ({1'b0, hold_ch_q} < (CH_W + 1)'(NUM_CH));
  assign hold_valid    = hold_in_range && (!hold_enable_q || (hold_period_q != '0));

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    apply_ok  = 1'b0;
    apply_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg_ready = 1'b1;
        accept    = cfg_valid;
        if (cfg_valid) state_d = StApply;
      end
      StApply: begin
        state_d   = StIdle;
        apply_ok  = hold_valid;
        apply_bad = !hold_valid;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      period_d[i] = period_q[i];
      en_d[i]     = en_q[i];
      if (!en_q[i] || (cnt_q[i] == period_q[i] - CNT_W'(1))) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // A write restarts the phase so no stale tick follows the reconfiguration.
      if (apply_ok && (hold_ch_q == CH_W'(i))) begin
        period_d[i] = hold_period_q;
        en_d[i]     = hold_enable_q;
        cnt_d[i]    = '0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      tick[i] = en_q[i] && (cnt_q[i] == period_q[i] - CNT_W'(1));
    end
  end

  assign active  = en_q;
  assign cfg_err = err_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      hold_ch_q     <= '0;
      hold_period_q <= '0;
      hold_enable_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= apply_bad;
      if (accept) begin
        hold_ch_q     <= cfg_ch;
        hold_period_q <= cfg_period;
        hold_enable_q <= cfg_enable;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      en_q <= en_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed and random checks of tick_scheduler against a time-based model:
// a channel applied at edge A with period P ticks after edge n when (n-A) mod P == P-1.
module tb_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 23;
  localparam int CH_W   = 4;

  logic              clock_in;
  logic              reset_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_enable;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] active;

  tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_enable(cfg_enable),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .active    (active)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  longint n_edge = 0;
  bit     m_en [NUM_CH];
  longint m_p  [NUM_CH];
  longint m_a  [NUM_CH];
  bit     m_pend;
  bit     m_err;
  int     h_ch;
  longint h_p;
  bit     h_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) begin
      v[i] = m_en[i] && (((n_edge - m_a[i]) % m_p[i]) == m_p[i] - 1);
    end
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_active();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_en[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".tick"},   64'(tick),      64'(exp_tick()));
    chk({tag, ".active"}, 64'(active),    64'(exp_active()));
    chk({tag, ".err"},    64'(cfg_err),   64'(m_err));
    chk({tag, ".ready"},  64'(cfg_ready), 64'(!m_pend));
  endtask

  // One clock edge: advance model, then sample 1 time unit after the edge.
  task automatic step(input string tag);
    bit acc;
    acc = cfg_valid && !m_pend;
    @(posedge clock_in);
    n_edge++;
    m_err = 1'b0;
    if (m_pend) begin
      if (h_ch < NUM_CH && (!h_en || h_p != 0)) begin
        m_en[h_ch] = h_en;
        m_p[h_ch]  = h_p;
        m_a[h_ch]  = n_edge;
      end else begin
        m_err = 1'b1;
      end
    end
    m_pend = acc;
    if (acc) begin
      h_ch = int'(cfg_ch);
      h_p  = longint'(cfg_period);
      h_en = cfg_enable;
    end
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int k);
    for (int i = 0; i < k; i++) step(tag);
  endtask

  task automatic wr(input string tag, input int ch, input longint p, input bit en);
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(p);
    cfg_enable = en;
    step(tag);
    cfg_valid = 1'b0;
    step(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    m_pend = 1'b0;
    m_err  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_en[i] = 1'b0;
      m_p[i]  = 1;
      m_a[i]  = 0;
    end
    check_all(tag);
    @(negedge clock_in);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_enable = 1'b0;
    #2;
    do_reset("reset");

    // First accept on first edge after release, then ch0 period 4
    wr("ch0_p4", 0, 4, 1'b1);
    run("ch0_p4_run", 13);

    wr("ch1_p1", 1, 1, 1'b1);
    run("ch1_p1_run", 4);

    // ch2 restart mid-count
    wr("ch2_p5", 2, 5, 1'b1);
    run("ch2_p5_run", 1);
    wr("ch2_p3", 2, 3, 1'b1);
    run("ch2_p3_run", 7);

    // Invalid requests
    wr("bad_ch", NUM_CH, 5, 1'b1);
    run("bad_ch_run", 2);
    wr("bad_p0", 0, 0, 1'b1);
    run("bad_p0_run", 2);

    // Stop with period 0 is legal
    wr("stop_ch1", 1, 0, 1'b0);
    run("stop_ch1_run", 3);

    // Back-to-back valid held for 6 cycles
    for (int k = 0; k < 6; k++) begin
      cfg_valid  = 1'b1;
      cfg_ch     = CH_W'(k % NUM_CH);
      cfg_period = CNT_W'(k + 2);
      cfg_enable = 1'b1;
      step("b2b");
    end
    cfg_valid = 1'b0;
    run("b2b_run", 10);

    // Maximum period
    wr("pmax", 1, (64'd1 << CNT_W) - 1, 1'b1);
    run("pmax_run", 3);

    // Reset during APPLY of ch3
    do_reset("reset2");
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(3);
    cfg_period = CNT_W'(2);
    cfg_enable = 1'b1;
    step("ch3_accept");
    cfg_valid = 1'b0;
    do_reset("reset_in_apply");
    run("after_reset", 6);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cfg_valid  = ($urandom_range(0, 2) != 0);
      cfg_ch     = CH_W'($urandom_range(0, 5));
      cfg_period = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom)
                                                : CNT_W'($urandom_range(0, 9));
      cfg_enable = ($urandom_range(0, 4) != 0);
      step("rand");
    end
    cfg_valid = 1'b0;
    run("rand_tail", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
